// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Ceiling log2 for constant elaboration; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register, set by reserve, cleared by write.
// Latency: set/clear take effect at the rising edge; busy reads and any-busy are combinational.
// Backpressure: none; every set/clear request is accepted every cycle.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset (clears all busy bits)
//   i_set_vld, i_set_addr      mark a register busy
//   i_clr_vld, i_clr_addr      mark a register no longer busy
//   i_rd1_addr, i_rd2_addr     busy read addresses
//   o_rd1_busy, o_rd2_busy     busy bit of the addressed register
//   o_any_busy                 OR of all busy bits
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_set_vld,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_vld,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd1_addr,
  input  logic [ADDR_W-1:0] i_rd2_addr,
  output logic              o_rd1_busy,
  output logic              o_rd2_busy,
  output logic              o_any_busy
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Clear is applied first so that a reserve to the same address in the
  // same cycle wins: the new producer is still outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_vld) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_vld) w_busy_nxt[i_set_addr] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_rd1_busy = r_busy[i_rd1_addr];
  assign o_rd2_busy = r_busy[i_rd2_addr];
  assign o_any_busy = |r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, one write port, two read ports.
// Latency: writes/reserves land at the rising edge; reads are combinational (same-cycle
//   write bypass when REG_FILE_BYPASS_EN is defined). Backpressure: none, always ready.
//
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding; off by default).
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-low reset (clears data and busy)
//   IN, INADDRESS, WRITE       write data/address/enable (write also clears busy)
//   RSVADDRESS, RESERVE        reservation address/enable (sets busy)
//   OUT1ADDRESS, OUT2ADDRESS   read addresses
//   OUT1, OUT2                 read data
//   OUT1BUSY, OUT2BUSY         busy bit of the addressed register
//   ANYBUSY                    OR of all busy bits
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] RSVADDRESS,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic              OUT1BUSY,
  output logic              OUT2BUSY,
  output logic              ANYBUSY
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_wr_en;
  logic             w_rsv_en;
  logic [WIDTH-1:0] w_rd1_dat;
  logic [WIDTH-1:0] w_rd2_dat;
  logic             w_sb_busy1;
  logic             w_sb_busy2;

  // With a hard-wired register 0, writes and reservations to it are
  // dropped here, so reg 0 keeps its reset value (zero) and never goes busy.
  assign w_wr_en  = WRITE   && !((ZERO_REG != 0) && (INADDRESS  == '0));
  assign w_rsv_en = RESERVE && !((ZERO_REG != 0) && (RSVADDRESS == '0));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[INADDRESS] <= IN;
    end
  end

  assign w_rd1_dat = r_mem[OUT1ADDRESS];
  assign w_rd2_dat = r_mem[OUT2ADDRESS];

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_set_vld  (w_rsv_en),
    .i_set_addr (RSVADDRESS),
    .i_clr_vld  (w_wr_en),
    .i_clr_addr (INADDRESS),
    .i_rd1_addr (OUT1ADDRESS),
    .i_rd2_addr (OUT2ADDRESS),
    .o_rd1_busy (w_sb_busy1),
    .o_rd2_busy (w_sb_busy2),
    .o_any_busy (ANYBUSY)
  );

`ifdef REG_FILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // Forward the in-flight write; the forwarded value is only still pending
  // if a new reservation lands on the same register this cycle.
  assign w_byp1 = w_wr_en && (INADDRESS == OUT1ADDRESS);
  assign w_byp2 = w_wr_en && (INADDRESS == OUT2ADDRESS);

  assign OUT1     = w_byp1 ? IN : w_rd1_dat;
  assign OUT2     = w_byp2 ? IN : w_rd2_dat;
  assign OUT1BUSY = w_byp1 ? (w_rsv_en && (RSVADDRESS == OUT1ADDRESS)) : w_sb_busy1;
  assign OUT2BUSY = w_byp2 ? (w_rsv_en && (RSVADDRESS == OUT2ADDRESS)) : w_sb_busy2;
`else
  assign OUT1     = w_rd1_dat;
  assign OUT2     = w_rd2_dat;
  assign OUT1BUSY = w_sb_busy1;
  assign OUT2BUSY = w_sb_busy2;
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: an 8x8 instance checked against a small
// reference model, and a 32x16 instance with hard-wired register 0 checked
// against constants. Expectations are queued when stimulus is set up and
// popped when the outputs are sampled.
module tb_reg_file_sb;

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        any;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  // Instance A: defaults (WIDTH 8, DEPTH 8, ZERO_REG 0)
  logic [7:0] a_in      = '0;
  logic [2:0] a_inaddr  = '0;
  logic       a_wr      = 1'b0;
  logic [2:0] a_rsvaddr = '0;
  logic       a_rsv     = 1'b0;
  logic [2:0] a_o1a     = '0;
  logic [2:0] a_o2a     = '0;
  logic [7:0] a_out1, a_out2;
  logic       a_o1b, a_o2b, a_any;

  // Instance B: WIDTH 32, DEPTH 16, ZERO_REG 1
  logic [31:0] b_in      = '0;
  logic [3:0]  b_inaddr  = '0;
  logic        b_wr      = 1'b0;
  logic [3:0]  b_rsvaddr = '0;
  logic        b_rsv     = 1'b0;
  logic [3:0]  b_o1a     = '0;
  logic [3:0]  b_o2a     = '0;
  logic [31:0] b_out1, b_out2;
  logic        b_o1b, b_o2b, b_any;

  // Reference model for instance A
  logic [7:0] ma [8];
  logic [7:0] mb;

  always #5 CLK = ~CLK;

  reg_file_sb dut_a (
    .CLK(CLK), .RESET(RESET),
    .IN(a_in), .INADDRESS(a_inaddr), .WRITE(a_wr),
    .RSVADDRESS(a_rsvaddr), .RESERVE(a_rsv),
    .OUT1ADDRESS(a_o1a), .OUT2ADDRESS(a_o2a),
    .OUT1(a_out1), .OUT2(a_out2),
    .OUT1BUSY(a_o1b), .OUT2BUSY(a_o2b), .ANYBUSY(a_any)
  );

  reg_file_sb #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1)) dut_b (
    .CLK(CLK), .RESET(RESET),
    .IN(b_in), .INADDRESS(b_inaddr), .WRITE(b_wr),
    .RSVADDRESS(b_rsvaddr), .RESERVE(b_rsv),
    .OUT1ADDRESS(b_o1a), .OUT2ADDRESS(b_o2a),
    .OUT1(b_out1), .OUT2(b_out2),
    .OUT1BUSY(b_o1b), .OUT2BUSY(b_o2b), .ANYBUSY(b_any)
  );

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ma[i] = '0;
    mb = '0;
  endtask

  // One rising edge; the model follows instance A's inputs when out of reset.
  task automatic tick();
    @(posedge CLK);
    if (RESET) begin
      if (a_wr) begin
        ma[a_inaddr] = a_in;
        mb[a_inaddr] = 1'b0;
      end
      if (a_rsv) mb[a_rsvaddr] = 1'b1;
    end
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] d1, input logic b1,
                      input logic [31:0] d2, input logic b2, input logic any);
    exp_t e;
    e.tag = tag; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.any = any;
    q.push_back(e);
  endtask

  // Expected read-port view of instance A for the inputs currently driven.
  task automatic push_a(input string tag);
    logic [7:0] d1, d2;
    logic       b1, b2;
    d1 = ma[a_o1a]; b1 = mb[a_o1a];
    d2 = ma[a_o2a]; b2 = mb[a_o2a];
`ifdef REG_FILE_BYPASS_EN
    if (a_wr && a_inaddr == a_o1a) begin
      d1 = a_in; b1 = a_rsv && (a_rsvaddr == a_o1a);
    end
    if (a_wr && a_inaddr == a_o2a) begin
      d2 = a_in; b2 = a_rsv && (a_rsvaddr == a_o2a);
    end
`endif
    push(tag, {24'h0, d1}, b1, {24'h0, d2}, b2, |mb);
  endtask

  task automatic chk(input logic [31:0] d1, input logic b1, input logic [31:0] d2,
                     input logic b2, input logic any);
    exp_t e;
    vectors++;
    assert (q.size() > 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0d expected>0", q.size());
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors += 4;
      assert (d1 === e.d1) else begin
        miscompares++; $error("FAIL %s OUT1 observed=%0h expected=%0h", e.tag, d1, e.d1);
      end
      assert (b1 === e.b1) else begin
        miscompares++; $error("FAIL %s OUT1BUSY observed=%0b expected=%0b", e.tag, b1, e.b1);
      end
      assert (d2 === e.d2) else begin
        miscompares++; $error("FAIL %s OUT2 observed=%0h expected=%0h", e.tag, d2, e.d2);
      end
      assert (b2 === e.b2) else begin
        miscompares++; $error("FAIL %s OUT2BUSY observed=%0b expected=%0b", e.tag, b2, e.b2);
      end
      vectors++;
      assert (any === e.any) else begin
        miscompares++; $error("FAIL %s ANYBUSY observed=%0b expected=%0b", e.tag, any, e.any);
      end
    end
  endtask

  task automatic check_a();
    chk({24'h0, a_out1}, a_o1b, {24'h0, a_out2}, a_o2b, a_any);
  endtask

  task automatic check_b();
    chk(b_out1, b_o1b, b_out2, b_o2b, b_any);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    // Reset state of both instances
    #2;
    push_a("reset_a"); check_a();
    push("reset_b", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0); check_b();
    @(negedge CLK);
    RESET = 1'b1;

    // Fill regs 0-7 with 0x11..0x88, reserving reg 3 on the last write
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_inaddr = 3'(i); a_in = 8'((i + 1) * 8'h11);
      a_rsv = (i == 7); a_rsvaddr = 3'd3;
      tick();
    end
    a_wr = 1'b0; a_rsv = 1'b0;
    a_o1a = 3'd7; a_o2a = 3'd3; #1;
    push_a("fill"); check_a();

    // Asynchronous reset between edges drops data and reservations
    RESET = 1'b0; model_clear(); #1;
    for (int i = 0; i < 8; i++) begin
      a_o1a = 3'(i); a_o2a = 3'(7 - i); #1;
      push_a("async_reset"); check_a();
    end

    // Write at an edge while reset is held is ignored
    a_wr = 1'b1; a_inaddr = 3'd1; a_in = 8'h99; a_o1a = 3'd2; a_o2a = 3'd3;
    tick();
    a_wr = 1'b0; a_o1a = 3'd1; #1;
    push_a("write_in_reset"); check_a();
    @(negedge CLK);
    RESET = 1'b1;
    #1;

    // Reserve 5, then write it
    a_rsv = 1'b1; a_rsvaddr = 3'd5; tick(); a_rsv = 1'b0;
    a_o1a = 3'd0; a_o2a = 3'd5; #1;
    push_a("reserve5"); check_a();
    a_wr = 1'b1; a_inaddr = 3'd5; a_in = 8'h3C; tick(); a_wr = 1'b0; #1;
    push_a("write5"); check_a();

    // Reserving an already-busy register keeps it busy
    a_rsv = 1'b1; a_rsvaddr = 3'd6; tick(); tick(); a_rsv = 1'b0;
    a_o1a = 3'd6; a_o2a = 3'd5; #1;
    push_a("rereserve6"); check_a();

    // Same-edge write+reserve to reg 2; both ports on the same register
    a_wr = 1'b1; a_rsv = 1'b1; a_inaddr = 3'd2; a_rsvaddr = 3'd2; a_in = 8'h5A;
    tick(); a_wr = 1'b0; a_rsv = 1'b0;
    a_o1a = 3'd2; a_o2a = 3'd2; #1;
    push_a("wr_rsv2"); check_a();

    // Reg 4 holds 0x10, then a same-cycle read of an in-flight write
    a_wr = 1'b1; a_inaddr = 3'd4; a_in = 8'h10; tick();
    a_in = 8'h77; a_o1a = 3'd4; a_o2a = 3'd5; #1;
    push_a("bypass4_pre"); check_a();
    tick(); a_wr = 1'b0; #1;
    push_a("bypass4_post"); check_a();

    // In-flight write to busy reg 6: forwarded busy clears
    a_wr = 1'b1; a_inaddr = 3'd6; a_in = 8'h66; a_o1a = 3'd2; a_o2a = 3'd6; #1;
    push_a("bypass6_pre"); check_a();
    tick(); a_wr = 1'b0; #1;
    push_a("bypass6_post"); check_a();

    // In-flight write plus reserve to reg 1: forwarded busy stays set
    a_wr = 1'b1; a_rsv = 1'b1; a_inaddr = 3'd1; a_rsvaddr = 3'd1; a_in = 8'hAB;
    a_o1a = 3'd1; a_o2a = 3'd0; #1;
    push_a("bypass1_rsv_pre"); check_a();
    tick(); a_wr = 1'b0; a_rsv = 1'b0; #1;
    push_a("bypass1_rsv_post"); check_a();

    // Wide/deep instance: addr 13 written, neighbour 12 untouched
    b_wr = 1'b1; b_inaddr = 4'd13; b_in = 32'hDEADBEEF; tick(); b_wr = 1'b0;
    b_o1a = 4'd13; b_o2a = 4'd12; #1;
    push("b_deadbeef", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0); check_b();

    // Hard-wired register 0 ignores write and reserve
    b_wr = 1'b1; b_inaddr = 4'd0; b_in = 32'hFF; b_rsv = 1'b1; b_rsvaddr = 4'd0;
    b_o1a = 4'd0; b_o2a = 4'd13; #1;
    push("b_zero_pre", 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0); check_b();
    tick(); b_wr = 1'b0; b_rsv = 1'b0; #1;
    push("b_zero_post", 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0); check_b();

    // Reserve on a normal register of instance B
    b_rsv = 1'b1; b_rsvaddr = 4'd9; tick(); b_rsv = 1'b0;
    b_o2a = 4'd9; #1;
    push("b_reserve9", 32'h0, 1'b0, 32'h0, 1'b1, 1'b1); check_b();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
